// File: rtl/vid_pkg.sv
// Shared types and default widths for the raster timing generator.
package vid_pkg;

   localparam int unsigned CW_DEF   = 13;
   localparam int unsigned DIVW_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } vt_state_e;

   // Timing fields for one axis (horizontal or vertical).
   typedef struct packed {
      logic [CW_DEF-1:0] size;
      logic [CW_DEF-1:0] tend;
      logic [CW_DEF-1:0] s_start;
      logic [CW_DEF-1:0] s_end;
      logic              pol;
   } axis_cfg_t;

endpackage

// File: rtl/vid_axis_cnt.sv
// One raster axis: position counter with wrap, shadowed timing fields,
// blank/sync decode and sync polarity. Outputs are registered from next-state values.
module vid_axis_cnt
   import vid_pkg::*;
#(
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          run_i,
   input  logic          clr_i,
   input  logic          step_i,
   input  logic          load_i,
   input  axis_cfg_t     cfg_i,
   input  logic          idle_pol_i,
   output logic [CW-1:0] cnt_o,
   output logic          blank_o,
   output logic          sync_o,
   output logic [CW-1:0] cnt_d_c,
   output logic          blank_d_c,
   output logic          wrap_c
);

   axis_cfg_t     cfg_q;
   axis_cfg_t     cfg_d;
   logic [CW-1:0] cnt_q;
   logic          blank_q;
   logic          sync_q;
   logic          sync_d;
   logic          sync_raw;

   // Wrap is judged against the fields of the frame in progress.
   always_comb begin
      wrap_c = step_i & (cnt_q == CW'(cfg_q.tend));
      cfg_d  = load_i ? cfg_i : cfg_q;

      cnt_d_c = cnt_q;
      if (clr_i) begin
         cnt_d_c = '0;
      end else if (step_i) begin
         cnt_d_c = wrap_c ? '0 : cnt_q + CW'(1);
      end
   end

   // Decode uses the fields that will be live when cnt_d_c is presented.
   always_comb begin
      sync_raw  = (cnt_d_c >= CW'(cfg_d.s_start)) & (cnt_d_c < CW'(cfg_d.s_end));
      blank_d_c = 1'b1;
      sync_d    = idle_pol_i;
      if (run_i) begin
         blank_d_c = cnt_d_c >= CW'(cfg_d.size);
         sync_d    = sync_raw ^ cfg_d.pol;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_q   <= '0;
         cnt_q   <= '0;
         blank_q <= 1'b1;
         sync_q  <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         cnt_q   <= cnt_d_c;
         blank_q <= blank_d_c;
         sync_q  <= sync_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign blank_o = blank_q;
   assign sync_o  = sync_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator: enable FSM, pixel divider, frame-boundary shadowing
// and pixel/line/frame pulses around two axis counters.
module vid_timing_gen
   import vid_pkg::*;
#(
   parameter int unsigned CW   = CW_DEF,
   parameter int unsigned DIVW = DIVW_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [DIVW-1:0] pcnt,
   input  logic [CW-1:0]   hsize,
   input  logic [CW-1:0]   hend,
   input  logic [CW-1:0]   hs_start,
   input  logic [CW-1:0]   hs_end,
   input  logic [CW-1:0]   vsize,
   input  logic [CW-1:0]   vend,
   input  logic [CW-1:0]   vs_start,
   input  logic [CW-1:0]   vs_end,
   input  logic            hpol,
   input  logic            vpol,
   output logic            hsync,
   output logic            hblank,
   output logic            vsync,
   output logic            vblank,
   output logic [CW-1:0]   hcnt,
   output logic [CW-1:0]   vcnt,
   output logic            pix_ce,
   output logic            pix_rd,
   output logic            line_start,
   output logic            frame_start
);

   vt_state_e       state_q;
   vt_state_e       state_d;
   logic [DIVW-1:0] div_q;
   logic [DIVW-1:0] div_d;
   logic [DIVW-1:0] pcnt_q;
   logic [DIVW-1:0] pcnt_d;
   logic            pix_ce_q;
   logic            pix_ce_d;
   logic            pix_rd_q;
   logic            pix_rd_d;
   logic            line_start_q;
   logic            line_start_d;
   logic            frame_start_q;
   logic            frame_start_d;

   logic            run_q_c;
   logic            run_d_c;
   logic            clr_c;
   logic            tick_c;
   logic            load_c;
   logic            frame_wrap_c;

   axis_cfg_t       h_cfg;
   axis_cfg_t       v_cfg;
   logic [CW-1:0]   hcnt_d;
   logic [CW-1:0]   vcnt_d;
   logic            hblank_d;
   logic            vblank_d;
   logic            h_wrap;
   logic            v_wrap;

   // Next-state logic; en=0 in RUN abandons the frame immediately.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Divider, shadow load and pulse generation.
   always_comb begin
      run_q_c      = (state_q == RUN);
      run_d_c      = (state_d == RUN);
      clr_c        = ~(run_q_c & run_d_c);
      tick_c       = run_q_c & run_d_c & (div_q == pcnt_q);
      frame_wrap_c = h_wrap & v_wrap;
      load_c       = (state_q == LOAD) | frame_wrap_c;
      pcnt_d       = load_c ? pcnt : pcnt_q;

      div_d = div_q + DIVW'(1);
      if (clr_c || tick_c) begin
         div_d = '0;
      end

      pix_ce_d      = run_d_c & (div_d == '0);
      pix_rd_d      = pix_ce_d & ~hblank_d & ~vblank_d;
      line_start_d  = pix_ce_d & (hcnt_d == '0);
      frame_start_d = line_start_d & (vcnt_d == '0);
   end

   always_comb begin
      h_cfg = '{size:    CW_DEF'(hsize),
                tend:    CW_DEF'(hend),
                s_start: CW_DEF'(hs_start),
                s_end:   CW_DEF'(hs_end),
                pol:     hpol};
      v_cfg = '{size:    CW_DEF'(vsize),
                tend:    CW_DEF'(vend),
                s_start: CW_DEF'(vs_start),
                s_end:   CW_DEF'(vs_end),
                pol:     vpol};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         div_q         <= '0;
         pcnt_q        <= '0;
         pix_ce_q      <= 1'b0;
         pix_rd_q      <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         pcnt_q        <= pcnt_d;
         pix_ce_q      <= pix_ce_d;
         pix_rd_q      <= pix_rd_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Horizontal axis steps on each pixel tick.
   vid_axis_cnt #(.CW(CW)) u_h (
      .clk        (clk),
      .reset_n    (reset_n),
      .run_i      (run_d_c),
      .clr_i      (clr_c),
      .step_i     (tick_c),
      .load_i     (load_c),
      .cfg_i      (h_cfg),
      .idle_pol_i (hpol),
      .cnt_o      (hcnt),
      .blank_o    (hblank),
      .sync_o     (hsync),
      .cnt_d_c    (hcnt_d),
      .blank_d_c  (hblank_d),
      .wrap_c     (h_wrap)
   );

   // Vertical axis steps on each horizontal wrap.
   vid_axis_cnt #(.CW(CW)) u_v (
      .clk        (clk),
      .reset_n    (reset_n),
      .run_i      (run_d_c),
      .clr_i      (clr_c),
      .step_i     (h_wrap),
      .load_i     (load_c),
      .cfg_i      (v_cfg),
      .idle_pol_i (vpol),
      .cnt_o      (vcnt),
      .blank_o    (vblank),
      .sync_o     (vsync),
      .cnt_d_c    (vcnt_d),
      .blank_d_c  (vblank_d),
      .wrap_c     (v_wrap)
   );

   assign pix_ce      = pix_ce_q;
   assign pix_rd      = pix_rd_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen: reset, frame statistics, divider,
// polarity, shadow reload, disable/reset mid-frame and degenerate timings.
module tb_vid_timing_gen;

   localparam int unsigned CW   = 13;
   localparam int unsigned DIVW = 6;

   logic            clk     = 1'b0;
   logic            reset_n = 1'b1;
   logic            en      = 1'b0;
   logic [DIVW-1:0] pcnt;
   logic [CW-1:0]   hsize, hend, hs_start, hs_end;
   logic [CW-1:0]   vsize, vend, vs_start, vs_end;
   logic            hpol, vpol;
   logic            hsync, hblank, vsync, vblank;
   logic [CW-1:0]   hcnt, vcnt;
   logic            pix_ce, pix_rd, line_start, frame_start;

   int checks = 0;
   int errors = 0;
   int n_rd, n_ce, n_ls, n_fs, n_hs, n_vs, n_hb, n_vb;

   always #5 clk = ~clk;

   vid_timing_gen #(.CW(CW), .DIVW(DIVW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .pcnt        (pcnt),
      .hsize       (hsize),
      .hend        (hend),
      .hs_start    (hs_start),
      .hs_end      (hs_end),
      .vsize       (vsize),
      .vend        (vend),
      .vs_start    (vs_start),
      .vs_end      (vs_end),
      .hpol        (hpol),
      .vpol        (vpol),
      .hsync       (hsync),
      .hblank      (hblank),
      .vsync       (vsync),
      .vblank      (vblank),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .pix_ce      (pix_ce),
      .pix_rd      (pix_rd),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accumulate per-signal high counts over n clocks, sampling each cycle.
   task automatic measure(input int n);
      n_rd = 0; n_ce = 0; n_ls = 0; n_fs = 0;
      n_hs = 0; n_vs = 0; n_hb = 0; n_vb = 0;
      repeat (n) begin
         n_rd += int'(pix_rd);
         n_ce += int'(pix_ce);
         n_ls += int'(line_start);
         n_fs += int'(frame_start);
         n_hs += int'(hsync);
         n_vs += int'(vsync);
         n_hb += int'(hblank);
         n_vb += int'(vblank);
         step();
      end
   endtask

   task automatic wait_frame(input string tag, input int bound);
      int n = 0;
      while (frame_start !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      check(tag, 32'(frame_start), 1);
   endtask

   initial begin
      pcnt = 0; hsize = 8; hend = 14; hs_start = 10; hs_end = 12;
      vsize = 4; vend = 9; vs_start = 6; vs_end = 7; hpol = 0; vpol = 0;

      #2 reset_n = 1'b0;
      #1;
      check("rst hcnt",   32'(hcnt), 0);
      check("rst vcnt",   32'(vcnt), 0);
      check("rst hblank", 32'(hblank), 1);
      check("rst vblank", 32'(vblank), 1);
      check("rst hsync",  32'(hsync), 0);
      check("rst vsync",  32'(vsync), 0);
      check("rst pix_ce", 32'(pix_ce), 0);
      check("rst pix_rd", 32'(pix_rd), 0);
      check("rst fs",     32'(frame_start), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      step();
      check("idle hsync",  32'(hsync), 0);
      check("idle hblank", 32'(hblank), 1);
      en = 1'b1;
      step();
      check("load fs",     32'(frame_start), 0);
      check("load hblank", 32'(hblank), 1);
      step();
      check("run0 fs",     32'(frame_start), 1);
      check("run0 pix_ce", 32'(pix_ce), 1);
      check("run0 pix_rd", 32'(pix_rd), 1);
      check("run0 hcnt",   32'(hcnt), 0);

      // Base frame, pcnt=0: 150 clk.
      measure(150);
      check("f0 pix_rd", 32'(n_rd), 32);
      check("f0 pix_ce", 32'(n_ce), 150);
      check("f0 line",   32'(n_ls), 10);
      check("f0 fs",     32'(n_fs), 1);
      check("f0 hsync",  32'(n_hs), 20);
      check("f0 vsync",  32'(n_vs), 15);
      check("f0 hblank", 32'(n_hb), 70);
      check("f0 vblank", 32'(n_vb), 90);
      check("f0 next fs", 32'(frame_start), 1);

      // pcnt written mid-frame applies from the next frame.
      pcnt = 4;
      measure(150);
      check("f1 pix_ce", 32'(n_ce), 150);
      check("f1 next fs", 32'(frame_start), 1);
      measure(750);
      check("f2 pix_rd", 32'(n_rd), 32);
      check("f2 pix_ce", 32'(n_ce), 150);
      check("f2 hsync",  32'(n_hs), 100);
      check("f2 line",   32'(n_ls), 10);
      check("f2 fs",     32'(n_fs), 1);
      check("f2 next fs", 32'(frame_start), 1);

      pcnt = 0; hpol = 1; vpol = 1;
      repeat (4) step();
      check("div hold hcnt", 32'(hcnt), 0);
      check("div hold ce",   32'(pix_ce), 0);
      step();
      check("div adv hcnt",  32'(hcnt), 1);
      check("div adv ce",    32'(pix_ce), 1);
      wait_frame("f3 end", 800);

      // Inverted polarity frame.
      measure(150);
      check("pol hsync hi", 32'(n_hs), 130);
      check("pol vsync hi", 32'(n_vs), 135);
      check("pol pix_rd",   32'(n_rd), 32);

      en = 1'b0;
      step();
      check("off hsync",  32'(hsync), 1);
      check("off vsync",  32'(vsync), 1);
      check("off hblank", 32'(hblank), 1);
      en = 1'b1;
      step();
      check("reload fs", 32'(frame_start), 0);
      step();
      check("rerun fs",  32'(frame_start), 1);

      // Disable mid-frame at (5,2).
      repeat (35) step();
      check("mid hcnt", 32'(hcnt), 5);
      check("mid vcnt", 32'(vcnt), 2);
      en = 1'b0;
      step();
      check("abort hcnt",   32'(hcnt), 0);
      check("abort vcnt",   32'(vcnt), 0);
      check("abort hblank", 32'(hblank), 1);
      check("abort vblank", 32'(vblank), 1);
      check("abort pix_ce", 32'(pix_ce), 0);
      check("abort pix_rd", 32'(pix_rd), 0);
      en = 1'b1; hpol = 0; vpol = 0;
      step();
      check("re-en +1 fs", 32'(frame_start), 0);
      step();
      check("re-en +2 fs", 32'(frame_start), 1);

      // hsize written on line 2: current frame keeps 8 active pixels.
      repeat (30) step();
      check("line2 vcnt", 32'(vcnt), 2);
      hsize = 6;
      measure(120);
      check("shadow old rd", 32'(n_rd), 16);
      check("shadow fs", 32'(frame_start), 1);
      measure(150);
      check("shadow new rd", 32'(n_rd), 24);

      // Asynchronous reset mid-frame.
      repeat (3) step();
      #2 reset_n = 1'b0;
      #1;
      check("areset hcnt",   32'(hcnt), 0);
      check("areset hblank", 32'(hblank), 1);
      check("areset vblank", 32'(vblank), 1);
      check("areset hsync",  32'(hsync), 0);
      en = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Degenerate: hend=0, empty hsync window.
      hsize = 8; hend = 0; hs_start = 12; hs_end = 12;
      en = 1'b1;
      step();
      step();
      check("deg fs", 32'(frame_start), 1);
      measure(10);
      check("deg hsync",  32'(n_hs), 0);
      check("deg line",   32'(n_ls), 10);
      check("deg pix_ce", 32'(n_ce), 10);
      check("deg hblank", 32'(n_hb), 0);
      check("deg pix_rd", 32'(n_rd), 4);
      check("deg vsync",  32'(n_vs), 1);
      check("deg wrap fs", 32'(frame_start), 1);
      repeat (3) step();
      check("deg vcnt", 32'(vcnt), 3);
      check("deg ls",   32'(line_start), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
